// File: rtl/race_timer_pkg.sv
// Shared types and defaults for the DeathRace frame-based race clock.
// Optional BCD outputs of race_timer are enabled by defining RACE_TIMER_BCD_EN.
package race_timer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        RUN       = 2'd2,
        EXPIRED   = 2'd3
    } race_state_e;

    localparam int DEF_FRAME_RATE        = 60;
    localparam int DEF_RACE_SECONDS      = 90;
    localparam int DEF_COUNTDOWN_SECONDS = 3;
    localparam int SEC_W                 = 8;

    // Counter width that stays legal when the divider ratio is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/race_timer_frame_tick_gen.sv
// Vsync rising-edge detector and FRAME_RATE divider producing a one-cycle
// sec_tick on the frame edge that completes an enabled second.
module frame_tick_gen
    import race_timer_pkg::*;
#(
    parameter int FRAME_RATE = DEF_FRAME_RATE
) (
    input  logic pclk,
    input  logic rst,
    input  logic vsync_in,
    input  logic enable,
    input  logic clear,
    output logic sec_tick
);

    localparam int CNT_W = cnt_width(FRAME_RATE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_RATE - 1);

    logic             vs_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             frame_edge;

    assign frame_edge = vsync_in & ~vs_q;
    // Edges arriving while disabled (paused or outside a race) are dropped.
    assign sec_tick   = frame_edge & enable & (frame_cnt_q == LAST);

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            vs_q        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vs_q <= vsync_in;
            if (clear) begin
                frame_cnt_q <= '0;
            end else if (frame_edge && enable) begin
                frame_cnt_q <= (frame_cnt_q == LAST) ? '0 : frame_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/race_timer.sv
// Race clock: pre-race countdown, race countdown and timeout level for the
// master FSM. Define RACE_TIMER_BCD_EN to add BCD copies of seconds_left.
module race_timer
    import race_timer_pkg::*;
#(
    parameter int FRAME_RATE        = DEF_FRAME_RATE,
    parameter int RACE_SECONDS      = DEF_RACE_SECONDS,
    parameter int COUNTDOWN_SECONDS = DEF_COUNTDOWN_SECONDS
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             vsync_in,
    input  logic             start,
    input  logic             pause,
    output logic [SEC_W-1:0] seconds_left,
    output logic [1:0]       countdown,
    output logic             race_active,
    output logic             time_out,
    output logic             tick_1hz,
    output race_state_e      state_dbg
`ifdef RACE_TIMER_BCD_EN
    ,
    output logic [3:0]       secs_tens,
    output logic [3:0]       secs_ones
`endif
);

    localparam logic [SEC_W-1:0] RACE_LOAD = SEC_W'(RACE_SECONDS);
    localparam logic [1:0]       CD_LOAD   = 2'(COUNTDOWN_SECONDS);

    race_state_e      state_q;
    logic [SEC_W-1:0] seconds_left_q;
    logic [1:0]       countdown_q;
    logic             race_active_q;
    logic             time_out_q;
    logic             tick_q;
    logic             start_q;
    logic             start_rise;
    logic             sec_tick;
    logic             tick_enable;
    logic             tick_clear;

    assign start_rise  = start & ~start_q;
    assign tick_enable = ((state_q == COUNTDOWN) || (state_q == RUN)) & ~pause;
    assign tick_clear  = (state_q == IDLE) & start_rise;

    frame_tick_gen #(
        .FRAME_RATE(FRAME_RATE)
    ) u_tick (
        .pclk     (pclk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .enable   (tick_enable),
        .clear    (tick_clear),
        .sec_tick (sec_tick)
    );

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            seconds_left_q <= RACE_LOAD;
            countdown_q    <= 2'd0;
            race_active_q  <= 1'b0;
            time_out_q     <= 1'b0;
            tick_q         <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            tick_q  <= sec_tick;
            start_q <= start;
            if (state_q == IDLE) begin
                seconds_left_q <= RACE_LOAD;
                countdown_q    <= 2'd0;
                race_active_q  <= 1'b0;
                time_out_q     <= 1'b0;
                if (start_rise) begin
                    state_q     <= COUNTDOWN;
                    countdown_q <= CD_LOAD;
                end
            end else if (!start) begin
                // Abort outranks a coincident second tick.
                state_q        <= IDLE;
                seconds_left_q <= RACE_LOAD;
                countdown_q    <= 2'd0;
                race_active_q  <= 1'b0;
                time_out_q     <= 1'b0;
            end else begin
                case (state_q)
                    COUNTDOWN: begin
                        if (sec_tick) begin
                            if (countdown_q == 2'd1) begin
                                countdown_q   <= 2'd0;
                                state_q       <= RUN;
                                race_active_q <= 1'b1;
                            end else begin
                                countdown_q <= countdown_q - 2'd1;
                            end
                        end
                    end
                    RUN: begin
                        if (sec_tick) begin
                            if (seconds_left_q == SEC_W'(1)) begin
                                seconds_left_q <= '0;
                                state_q        <= EXPIRED;
                                race_active_q  <= 1'b0;
                                time_out_q     <= 1'b1;
                            end else if (seconds_left_q != '0) begin
                                seconds_left_q <= seconds_left_q - SEC_W'(1);
                            end
                        end
                    end
                    default: begin
                        seconds_left_q <= '0;
                        time_out_q     <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign seconds_left = seconds_left_q;
    assign countdown    = countdown_q;
    assign race_active  = race_active_q;
    assign time_out     = time_out_q;
    assign tick_1hz     = tick_q;
    assign state_dbg    = state_q;

`ifdef RACE_TIMER_BCD_EN
    localparam logic [3:0] TENS_LOAD = 4'(RACE_SECONDS / 10);
    localparam logic [3:0] ONES_LOAD = 4'(RACE_SECONDS % 10);

    logic [3:0] tens_q;
    logic [3:0] ones_q;

    // Follows exactly the same load/decrement events as seconds_left_q.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            tens_q <= TENS_LOAD;
            ones_q <= ONES_LOAD;
        end else if ((state_q == IDLE) || !start) begin
            tens_q <= TENS_LOAD;
            ones_q <= ONES_LOAD;
        end else if (state_q == EXPIRED) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else if ((state_q == RUN) && sec_tick && (seconds_left_q != '0)) begin
            if (seconds_left_q == SEC_W'(1)) begin
                tens_q <= 4'd0;
                ones_q <= 4'd0;
            end else if (ones_q == 4'd0) begin
                ones_q <= 4'd9;
                tens_q <= tens_q - 4'd1;
            end else begin
                ones_q <= ones_q - 4'd1;
            end
        end
    end

    assign secs_tens = tens_q;
    assign secs_ones = ones_q;
`endif

endmodule

// File: tb/tb_race_timer.sv
// Scoreboard bench for race_timer: a frame-counting reference model predicts
// every cycle's outputs into a queue that a negedge monitor drains and checks.
module tb_race_timer;
    import race_timer_pkg::*;

    localparam int FR   = 2;
    localparam int RACE = 3;
    localparam int CD   = 2;

    logic        pclk;
    logic        rst;
    logic        vsync_in;
    logic        start;
    logic        pause;
    logic [7:0]  seconds_left;
    logic [1:0]  countdown;
    logic        race_active;
    logic        time_out;
    logic        tick_1hz;
    race_state_e state_dbg;
`ifdef RACE_TIMER_BCD_EN
    logic [3:0]  secs_tens;
    logic [3:0]  secs_ones;
`endif

    race_timer #(
        .FRAME_RATE        (FR),
        .RACE_SECONDS      (RACE),
        .COUNTDOWN_SECONDS (CD)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .vsync_in     (vsync_in),
        .start        (start),
        .pause        (pause),
        .seconds_left (seconds_left),
        .countdown    (countdown),
        .race_active  (race_active),
        .time_out     (time_out),
        .tick_1hz     (tick_1hz),
        .state_dbg    (state_dbg)
`ifdef RACE_TIMER_BCD_EN
        ,
        .secs_tens    (secs_tens),
        .secs_ones    (secs_ones)
`endif
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int tick_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // reference model: counts unpaused frames since the race was armed
    logic [12:0] exp_q[$];
    int          n;
    bit          in_game;
    logic        vs_prev;
    logic        st_prev;

    always @(posedge pclk) begin
        logic       frame_e, rise_e, tk, ra, to;
        logic [7:0] sl;
        logic [1:0] cd;
        int         sec;
        if (!rst) begin
            n = 0; in_game = 0; vs_prev = 0; st_prev = 0;
            exp_q.push_back({8'(RACE), 2'd0, 1'b0, 1'b0, 1'b0});
        end else begin
            frame_e = vsync_in & ~vs_prev;
            rise_e  = start & ~st_prev;
            vs_prev = vsync_in;
            st_prev = start;
            tk = 1'b0;
            if (in_game && frame_e && !pause && (n / FR < CD + RACE)) begin
                n++;
                tk = (n % FR == 0);
            end
            if (!in_game) begin
                if (rise_e) begin in_game = 1; n = 0; end
            end else if (!start) begin
                in_game = 0;
            end
            sec = n / FR;
            if (!in_game) begin
                sl = 8'(RACE); cd = 2'd0; ra = 0; to = 0;
            end else if (sec < CD) begin
                sl = 8'(RACE); cd = 2'(CD - sec); ra = 0; to = 0;
            end else if (sec < CD + RACE) begin
                sl = 8'(RACE - (sec - CD)); cd = 2'd0; ra = 1; to = 0;
            end else begin
                sl = 8'd0; cd = 2'd0; ra = 0; to = 1;
            end
            exp_q.push_back({sl, cd, ra, to, tk});
        end
    end

    // monitor
    always @(negedge pclk) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", {19'd0, seconds_left, countdown, race_active, time_out, tick_1hz},
                {19'd0, e});
`ifdef RACE_TIMER_BCD_EN
            chk("bcd", {24'd0, secs_tens, secs_ones},
                {24'd0, 4'(e[12:5] / 10), 4'(e[12:5] % 10)});
`endif
        end
        if (tick_1hz) tick_cnt++;
    end

    // driver tasks
    task automatic cyc(input int k);
        repeat (k) @(posedge pclk);
        #2;
    endtask

    task automatic send_frame(input logic p, input logic s);
        vsync_in = 1'b1;
        pause    = p;
        start    = s;
        cyc(2);
        vsync_in = 1'b0;
        cyc(18);
    endtask

    initial begin
        rst = 1'b0; vsync_in = 1'b0; start = 1'b0; pause = 1'b0;
        cyc(5);
        rst = 1'b1;

        tick_cnt = 0;
        repeat (10) send_frame(1'b0, 1'b0);
        chk("idle_ticks", tick_cnt, 0);
        chk("idle_secs", seconds_left, RACE);
        chk("idle_cd", countdown, 0);
        chk("idle_to", time_out, 0);

        start = 1'b1;
        cyc(5);
        tick_cnt = 0;
        repeat (10) send_frame(1'b0, 1'b1);
        chk("race_ticks", tick_cnt, 5);
        chk("race_to", time_out, 1);
        chk("race_secs", seconds_left, 0);
        chk("race_state", state_dbg, EXPIRED);

        start = 1'b0;
        cyc(1);
        chk("abort_to", time_out, 0);
        chk("abort_secs", seconds_left, RACE);
        chk("abort_state", state_dbg, IDLE);
        start = 1'b1;
        cyc(2);
        chk("rearm_cd", countdown, CD);

        repeat (6) send_frame(1'b0, 1'b1);
        chk("pre_pause_secs", seconds_left, 2);
        tick_cnt = 0;
        repeat (6) send_frame(1'b1, 1'b1);
        chk("pause_secs", seconds_left, 2);
        chk("pause_ticks", tick_cnt, 0);
        send_frame(1'b0, 1'b1);
        chk("resume1_secs", seconds_left, 2);
        send_frame(1'b0, 1'b1);
        chk("resume2_secs", seconds_left, 1);

        send_frame(1'b0, 1'b1);
        send_frame(1'b0, 1'b0);
        chk("simul_to", time_out, 0);
        chk("simul_secs", seconds_left, RACE);
        chk("simul_state", state_dbg, IDLE);

        start = 1'b1;
        cyc(3);
        for (int i = 0; i < 40; i++) begin
            send_frame($urandom_range(0, 3) == 0,
                       ($urandom_range(0, 9) == 0) ? ~start : start);
        end

        start = 1'b0;
        cyc(2);
        start = 1'b1;
        cyc(2);
        repeat (6) send_frame(1'b0, 1'b1);
        chk("mid_run_secs", seconds_left, 2);
        @(negedge pclk);
        #2 rst = 1'b0;
        #1;
        chk("arst_secs", seconds_left, RACE);
        chk("arst_cd", countdown, 0);
        chk("arst_active", race_active, 0);
        chk("arst_to", time_out, 0);
        chk("arst_tick", tick_1hz, 0);
        chk("arst_state", state_dbg, IDLE);
        cyc(3);
        rst = 1'b1;
        cyc(5);

        @(negedge pclk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
